// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the scribble frame-RAM port arbiter.
//   arb_state_t  : arbiter FSM state (IDLE / CLEAR)
//   ADDR_W_DEF   : default RAM address width ({x[7:0], y[7:0]})
//   DATA_W_DEF   : default RAM word width (RGB bits)
//   CLR_VAL_DEF  : default word written by the clear sweep
package fb_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 3;
    localparam int unsigned CLR_VAL_DEF = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Trace-write queue: synchronous FIFO of {addr, data} entries.
//   i_clk, i_rst   : clock, asynchronous active-high reset (to empty)
//   i_flush        : discard all entries (wins over push/pop)
//   i_push         : enqueue {i_addr, i_data}; ignored when full
//   i_pop          : drop the head entry; ignored when empty
//   o_full/o_empty : occupancy flags
//   o_head_addr/o_head_data : current head entry
module fb_wr_fifo #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W+DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]           r_wr_ptr;
    logic [PTR_W:0]           r_rd_ptr;
    logic                     w_push;
    logic                     w_pop;

    // Extra MSB is the wrap bit: equal indices with differing wrap bits means full.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    assign {o_head_addr, o_head_data} = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr[PTR_W-1:0]] <= {i_addr, i_data};
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Owns the single port of the scribble frame RAM and shares it between the
// display read path, a whole-RAM clear sweep and queued pointer-trace writes.
//   clk, rst        : clock, asynchronous active-high reset
//   video_on/rd_addr: display read request (highest priority)
//   rd_data/rd_valid/rd_blank : read return, valid one cycle after grant, blanking
//   wr_req/wr_addr/wr_data    : one-cycle trace-write request into the queue
//   wr_full/wr_drop : queue full, request discarded this cycle
//   clr_start/clr_busy/clr_done : clear sweep control and status
//   ram_we/ram_addr/ram_din/ram_dout : RAM port (1-cycle read latency)
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter int unsigned       DATA_W     = DATA_W_DEF,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] CLR_VAL    = DATA_W'(CLR_VAL_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              video_on,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_blank,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_drop,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_clr_done;
    logic              r_rd_valid;

    logic              w_enter_clear;
    logic              w_clr_adv;
    logic              w_clr_last;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    assign w_enter_clear = (r_state == IDLE) && clr_start;
    assign w_clr_adv     = (r_state == CLEAR) && !video_on;
    assign w_clr_last    = w_clr_adv && (r_clr_cnt == '1);

    // Push into a full queue is dropped outright, even if the head pops this cycle.
    assign w_push = wr_req && (r_state == IDLE) && !clr_start && !w_full;
    assign w_pop  = !video_on && (r_state == IDLE) && !w_empty;

    fb_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (w_enter_clear),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_addr      (wr_addr),
        .i_data      (wr_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (clr_start)  w_state_nxt = CLEAR;
            CLEAR:   if (w_clr_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_clr_cnt  <= '0;
            r_clr_done <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_done <= w_clr_last;
            r_rd_valid <= video_on;
            if (w_enter_clear)  r_clr_cnt <= '0;
            else if (w_clr_adv) r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Grant mux; outputs forced idle while reset is asserted.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (!rst) begin
            if (video_on) begin
                ram_addr = rd_addr;
            end else if (r_state == CLEAR) begin
                ram_we   = 1'b1;
                ram_addr = r_clr_cnt;
                ram_din  = CLR_VAL;
            end else if (!w_empty) begin
                ram_we   = 1'b1;
                ram_addr = w_head_addr;
                ram_din  = w_head_data;
            end
        end
    end

    assign rd_data  = ram_dout;
    assign rd_valid = r_rd_valid;
    assign clr_busy = (r_state == CLEAR);
    assign rd_blank = clr_busy;
    assign clr_done = r_clr_done;
    assign wr_full  = w_full;
    assign wr_drop  = !rst && wr_req && !w_push;

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 3;
    localparam int unsigned N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          video_on;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_blank;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_full, wr_drop;
    logic          clr_start, clr_busy, clr_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .CLR_VAL    (3'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .video_on  (video_on),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_blank  (rd_blank),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .wr_drop   (wr_drop),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Inputs change 1 ns after the rising edge; checks happen 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; video_on = 1'b1; rd_addr = 12'h234;
        #1;
        n_chk++; if (ram_we !== 1'b0)    begin n_fail++; $display("FAIL rst_we got %0b want 0", ram_we); end
        n_chk++; if (ram_addr !== '0)    begin n_fail++; $display("FAIL rst_addr got %h want 000", ram_addr); end
        n_chk++; if (ram_din !== '0)     begin n_fail++; $display("FAIL rst_din got %h want 0", ram_din); end
        n_chk++; if ({rd_valid, wr_full, wr_drop, clr_busy, clr_done} !== 5'b0)
            begin n_fail++; $display("FAIL rst_flags got %b want 00000", {rd_valid, wr_full, wr_drop, clr_busy, clr_done}); end
        tick();
        video_on = 1'b0; rd_addr = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_video_priority();
        video_on = 1'b1; rd_addr = 12'h234;
        wr_req = 1'b1; wr_addr = 12'h505; wr_data = 3'd5;
        #1;
        n_chk++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL vp_rdv0 got %0b want 0", rd_valid); end
        n_chk++; if (ram_we !== 1'b0)    begin n_fail++; $display("FAIL vp_we0 got %0b want 0", ram_we); end
        n_chk++; if (ram_addr !== 12'h234) begin n_fail++; $display("FAIL vp_addr0 got %h want 234", ram_addr); end
        n_chk++; if (wr_drop !== 1'b0)   begin n_fail++; $display("FAIL vp_drop got %0b want 0", wr_drop); end
        tick();
        wr_req = 1'b0;
        #1;
        n_chk++; if (ram_we !== 1'b0)    begin n_fail++; $display("FAIL vp_we1 got %0b want 0", ram_we); end
        n_chk++; if (ram_addr !== 12'h234) begin n_fail++; $display("FAIL vp_addr1 got %h want 234", ram_addr); end
        n_chk++; if (rd_valid !== 1'b1)  begin n_fail++; $display("FAIL vp_rdv1 got %0b want 1", rd_valid); end
        tick();
        video_on = 1'b0;
        #1;
        n_chk++; if (ram_we !== 1'b1)    begin n_fail++; $display("FAIL vp_we2 got %0b want 1", ram_we); end
        n_chk++; if (ram_addr !== 12'h505) begin n_fail++; $display("FAIL vp_addr2 got %h want 505", ram_addr); end
        n_chk++; if (ram_din !== 3'd5)   begin n_fail++; $display("FAIL vp_din2 got %0d want 5", ram_din); end
        n_chk++; if (rd_valid !== 1'b1)  begin n_fail++; $display("FAIL vp_rdv2 got %0b want 1", rd_valid); end
        tick();
        #1;
        n_chk++; if (ram_we !== 1'b0)    begin n_fail++; $display("FAIL vp_we3 got %0b want 0", ram_we); end
        n_chk++; if (ram_addr !== '0)    begin n_fail++; $display("FAIL vp_addr3 got %h want 000", ram_addr); end
        n_chk++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL vp_rdv3 got %0b want 0", rd_valid); end
        tick();
    endtask

    task automatic test_fifo_full();
        video_on = 1'b1; rd_addr = 12'h0AA;
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_addr = AW'(12'h100 + i); wr_data = DW'(i + 1);
            #1;
            n_chk++; if (wr_drop !== (i == 4)) begin n_fail++; $display("FAIL ff_drop%0d got %0b want %0b", i, wr_drop, (i == 4)); end
            n_chk++; if (wr_full !== (i == 4)) begin n_fail++; $display("FAIL ff_full%0d got %0b want %0b", i, wr_full, (i == 4)); end
            tick();
        end
        wr_req = 1'b0;
        #1;
        n_chk++; if (wr_full !== 1'b1) begin n_fail++; $display("FAIL ff_full_hold got %0b want 1", wr_full); end
        tick();
        video_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL ff_we%0d got %0b want 1", i, ram_we); end
            n_chk++; if (ram_addr !== AW'(12'h100 + i)) begin n_fail++; $display("FAIL ff_addr%0d got %h want %h", i, ram_addr, AW'(12'h100 + i)); end
            n_chk++; if (ram_din !== DW'(i + 1)) begin n_fail++; $display("FAIL ff_din%0d got %0d want %0d", i, ram_din, i + 1); end
            tick();
        end
        #1;
        n_chk++; if (ram_we !== 1'b0)  begin n_fail++; $display("FAIL ff_we_end got %0b want 0", ram_we); end
        n_chk++; if (wr_full !== 1'b0) begin n_fail++; $display("FAIL ff_full_end got %0b want 0", wr_full); end
        tick();
    endtask

    task automatic test_clear_sweep();
        int errs = 0;
        video_on = 1'b0; clr_start = 1'b1;
        #1;
        n_chk++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL cs_busy_entry got %0b want 0", clr_busy); end
        n_chk++; if (ram_we !== 1'b0)   begin n_fail++; $display("FAIL cs_we_entry got %0b want 0", ram_we); end
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            #1;
            if (ram_we !== 1'b1 || ram_addr !== AW'(k) || ram_din !== '0 ||
                clr_busy !== 1'b1 || rd_blank !== 1'b1 || clr_done !== 1'b0) begin
                if (errs == 0) $display("note: first bad sweep cycle k=%0d we=%0b addr=%h din=%0d busy=%0b",
                                        k, ram_we, ram_addr, ram_din, clr_busy);
                errs++;
            end
            tick();
        end
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL cs_sweep bad cycles got %0d want 0", errs); end
        #1;
        n_chk++; if (clr_done !== 1'b1) begin n_fail++; $display("FAIL cs_done got %0b want 1", clr_done); end
        n_chk++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL cs_busy_end got %0b want 0", clr_busy); end
        n_chk++; if (rd_blank !== 1'b0) begin n_fail++; $display("FAIL cs_blank_end got %0b want 0", rd_blank); end
        n_chk++; if (ram_we !== 1'b0)   begin n_fail++; $display("FAIL cs_we_end got %0b want 0", ram_we); end
        tick();
        #1;
        n_chk++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL cs_done_pulse got %0b want 0", clr_done); end
        tick();
    endtask

    task automatic test_clear_video_toggle();
        int errs = 0;
        int cnt = 0;
        int c = 0;
        rd_addr = 12'h0AA; video_on = 1'b0; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        while (cnt < int'(N) && c < 4 * int'(N)) begin
            video_on = ((c / 10) % 2) == 0;
            #1;
            if (video_on) begin
                if (ram_we !== 1'b0 || ram_addr !== 12'h0AA || clr_busy !== 1'b1) errs++;
            end else begin
                if (ram_we !== 1'b1 || ram_addr !== AW'(cnt) || ram_din !== '0 || clr_busy !== 1'b1) errs++;
                cnt++;
            end
            c++;
            tick();
        end
        n_chk++; if (cnt != int'(N)) begin n_fail++; $display("FAIL vt_writes got %0d want %0d", cnt, N); end
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL vt_sweep bad cycles got %0d want 0", errs); end
        video_on = 1'b0;
        #1;
        n_chk++; if (clr_done !== 1'b1) begin n_fail++; $display("FAIL vt_done got %0b want 1", clr_done); end
        n_chk++; if (ram_we !== 1'b0)   begin n_fail++; $display("FAIL vt_we_end got %0b want 0", ram_we); end
        tick();
        #1;
        n_chk++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL vt_done_pulse got %0b want 0", clr_done); end
        tick();
    endtask

    task automatic test_clear_flush();
        int errs = 0;
        int done_cnt = 0;
        video_on = 1'b1;
        wr_req = 1'b1; wr_addr = 12'h111; wr_data = 3'd1;
        tick();
        wr_addr = 12'h222; wr_data = 3'd2;
        tick();
        clr_start = 1'b1; wr_addr = 12'h333; wr_data = 3'd3;
        #1;
        n_chk++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL fl_drop_start got %0b want 1", wr_drop); end
        n_chk++; if (ram_we !== 1'b0)  begin n_fail++; $display("FAIL fl_we_start got %0b want 0", ram_we); end
        tick();
        clr_start = 1'b0; wr_req = 1'b0; video_on = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            clr_start = (k == int'(N) / 2);
            wr_req    = (k == 10);
            #1;
            if (ram_we !== 1'b1 || ram_addr !== AW'(k) || ram_din !== '0) errs++;
            if (k == 10) begin
                n_chk++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL fl_drop_clear got %0b want 1", wr_drop); end
            end
            tick();
        end
        clr_start = 1'b0; wr_req = 1'b0;
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL fl_sweep bad cycles got %0d want 0", errs); end
        errs = 0;
        for (int j = 0; j < 8; j++) begin
            #1;
            if (clr_done === 1'b1) done_cnt++;
            if (ram_we !== 1'b0) errs++;
            tick();
        end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL fl_done_count got %0d want 1", done_cnt); end
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL fl_trailing_writes got %0d want 0", errs); end
    endtask

    task automatic test_reset_mid_sweep();
        int errs = 0;
        video_on = 1'b0; rd_addr = 12'h0AA; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < int'(N) / 2; k++) tick();
        video_on = 1'b1;
        #1;
        n_chk++; if (ram_addr !== 12'h0AA) begin n_fail++; $display("FAIL rm_read_addr got %h want 0aa", ram_addr); end
        tick();
        video_on = 1'b0;
        #1;
        n_chk++; if (ram_addr !== AW'(N / 2)) begin n_fail++; $display("FAIL rm_cnt got %h want %h", ram_addr, AW'(N / 2)); end
        n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rm_rdv_pre got %0b want 1", rd_valid); end
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (ram_we !== 1'b0)   begin n_fail++; $display("FAIL rm_we got %0b want 0", ram_we); end
        n_chk++; if (ram_addr !== '0)   begin n_fail++; $display("FAIL rm_addr got %h want 000", ram_addr); end
        n_chk++; if ({rd_valid, clr_busy, rd_blank, clr_done, wr_full, wr_drop} !== 6'b0)
            begin n_fail++; $display("FAIL rm_flags got %b want 000000", {rd_valid, clr_busy, rd_blank, clr_done, wr_full, wr_drop}); end
        tick();
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            if (clr_busy !== 1'b0 || clr_done !== 1'b0 || ram_we !== 1'b0) errs++;
            tick();
        end
        n_chk++; if (errs != 0) begin n_fail++; $display("FAIL rm_post_idle bad cycles got %0d want 0", errs); end
        wr_req = 1'b1; wr_addr = 12'h0F0; wr_data = 3'd6;
        #1;
        n_chk++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL rm_wr_drop got %0b want 0", wr_drop); end
        tick();
        wr_req = 1'b0;
        #1;
        n_chk++; if (ram_we !== 1'b1 || ram_addr !== 12'h0F0 || ram_din !== 3'd6)
            begin n_fail++; $display("FAIL rm_wr got we=%0b addr=%h din=%0d want we=1 addr=0f0 din=6", ram_we, ram_addr, ram_din); end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; video_on = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clr_start = 1'b0; ram_dout = 3'd2;
        #12;
        test_reset();
        test_video_priority();
        test_fifo_full();
        test_clear_sweep();
        test_clear_video_toggle();
        test_clear_flush();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Owns the single port of the synchronous scribble frame RAM (64K x 3, address = {x[7:0], y[7:0]}).
- Shares that port between three users:
  - Display read path (highest priority while video is active).
  - Whole-RAM clear sweep.
  - Queued pointer-trace writes.
- Sits between the mouse/trace logic and the single_port_syn instance. Replaces ad-hoc we/addr muxing and single-cycle write windows.

Parameters:
- ADDR_W, 16, RAM address width; clear sweeps 2^ADDR_W words.
- DATA_W, 3, RAM word width (RGB bits).
- FIFO_DEPTH, 4, trace-write queue depth; power of two, at least 2.
- CLR_VAL, 0, word written by the clear sweep.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- video_on  in  1  display is reading this cycle; grants the port to rd_addr.
- rd_addr  in  ADDR_W  display read address.
- rd_data  out  DATA_W  equals ram_dout; meaningful when rd_valid=1.
- rd_valid  out  1  read was granted the previous cycle.
- rd_blank  out  1  =clr_busy; display forces black while high.
- wr_req  in  1  one-cycle trace-write request.
- wr_addr  in  ADDR_W  trace-write address.
- wr_data  in  DATA_W  trace-write colour.
- wr_full  out  1  queue holds FIFO_DEPTH entries.
- wr_drop  out  1  one-cycle pulse: the request this cycle was discarded.
- clr_start  in  1  one-cycle pulse: begin clear sweep.
- clr_busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data; 1-cycle latency.

Behaviour:
- Reset (async, rst=1): state IDLE; queue empty; clear counter 0; rd_valid, wr_full, wr_drop, clr_busy and clr_done all 0.
- While in reset, the RAM-port outputs are ram_we=0, ram_addr=0, ram_din=0.
- Reset mid-sweep aborts the sweep. The RAM is left partially cleared and no clr_done is issued.
- RAM-port grant is combinational, evaluated each cycle in this priority order:
  1. video_on=1: ram_we=0, ram_addr=rd_addr.
  2. state CLEAR: ram_we=1, ram_addr=clr_cnt, ram_din=CLR_VAL; clr_cnt increments.
  3. IDLE with the queue non-empty: ram_we=1, ram_addr and ram_din from the queue head; head popped this cycle.
  4. Otherwise: ram_we=0, ram_addr=0.
- rd_valid is registered: rd_valid(t+1) = video_on(t).
- States:
  - IDLE -> CLEAR on clr_start. Entering CLEAR flushes the queue and clears clr_cnt to 0.
  - CLEAR -> IDLE after the cycle that writes address all-ones. clr_done=1 on the following cycle; clr_busy=0 from that cycle on.
  - clr_start during CLEAR is ignored; the sweep does not restart.
- Sweep timing:
  - clr_cnt advances only in cycles with video_on=0. A sweep spans several frames if blanking is short.
  - Minimum sweep length is 2^ADDR_W cycles.
- Trace-write queue:
  - Push when wr_req=1, state IDLE, no clr_start this cycle, and the queue is not full.
  - Pushing into a full queue is discarded with wr_drop=1. Push-when-full is never combined with a same-cycle pop.
  - Push and pop in the same cycle on a non-empty queue leave the count unchanged.
  - Pushing into an empty queue is not visible to the grant logic until the next cycle; there is no bypass.
  - wr_req during CLEAR, or in the same cycle as clr_start, is discarded with wr_drop=1.
- Width rules:
  - clr_cnt is ADDR_W bits and wraps to 0 at the end of the sweep.
  - Queue pointers are log2(FIFO_DEPTH) bits plus a wrap bit.

Decomposition:
- Package fb_arb_pkg holds:
  - state enum {IDLE, CLEAR};
  - default ADDR_W and DATA_W;
  - CLR_VAL.
- One sub-module, fb_wr_fifo: synchronous FIFO of {addr, data} with push, pop, full, empty and head outputs; reset to empty.
- The arbiter keeps the FSM, clear counter, grant mux and rd_valid register.

Test Plan:
1. video_on=1, rd_addr=0x1234 while wr_req pushes {0x0505, 3'b101} -> ram_we stays 0 and ram_addr=0x1234 while video_on=1. When video_on falls, ram_we=1 with ram_addr=0x0505, ram_din=5 in the same cycle. rd_valid lags video_on by exactly one cycle.
2. Five wr_req with video_on=1 and FIFO_DEPTH=4 -> wr_full=1 after the 4th request; wr_drop pulses on the 5th. After video_on=0, exactly 4 writes occur in request order, then ram_we=0.
3. clr_start with video_on=0 held -> 65536 consecutive writes of 0 at addresses 0x0000..0xFFFF. clr_done pulses at cycle 65537 after entry; clr_busy and rd_blank are 1 throughout the sweep.
4. clr_start with video_on toggling 10 cycles on / 10 off -> clr_cnt frozen while video_on=1. Total of 65536 clear writes; no address skipped or repeated.
5. Two queued writes, then clr_start plus a same-cycle wr_req -> queue flushed, that wr_req gets wr_drop, no trace writes occur. A second clr_start at mid-sweep is ignored and clr_done appears exactly once.
6. rst pulsed at clr_cnt=0x8000 -> all outputs 0 immediately (asynchronous). Afterwards the state is IDLE with no clr_done; a new wr_req is accepted normally.
